dcache_blk_master: RTL and testbench

Initiator for the data-cache word port: moves one 128-bit AES block (four 32-bit words) between a register interface and the dcache. Loads read four consecutive words into a 128-bit output, for example key at word 0 or plaintext at word 4. Stores write a 128-bit result, such as ciphertext, back as four consecutive words. It sits between the AES datapath/controller and the dcache `we/re/addr/wdata/rdata` port, and owns that port whenever it is busy.

---
 rtl/dcbm_pkg.sv | 43 ++++
 rtl/dcache_blk_master.sv | 151 +++++++++++++++
 tb/tb_dcache_blk_master.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/dcbm_pkg.sv
// Shared types and constants for the dcache block master.
// Holds the FSM encoding, block geometry and the AES data-map bases.
package dcbm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        STORE = 2'd2
    } state_t;

    localparam int BLK_WORDS    = 4;
    localparam int DCACHE_DEPTH = 384;

    localparam logic [31:0] KEY_BASE  = 32'd0;
    localparam logic [31:0] PT_BASE   = 32'd4;
    localparam logic [31:0] SBOX_BASE = 32'd128;

    // Word k of a block sits at bits [127-32k -: 32], most significant word first.
    function automatic logic [31:0] blk_word(input logic [127:0] blk, input logic [1:0] k);
        logic [31:0] w;
        case (k)
            2'd0:    w = blk[127:96];
            2'd1:    w = blk[95:64];
            2'd2:    w = blk[63:32];
            default: w = blk[31:0];
        endcase
        return w;
    endfunction

    function automatic logic [127:0] blk_put(input logic [127:0] blk, input logic [1:0] k,
                                             input logic [31:0] w);
        logic [127:0] r;
        r = blk;
        case (k)
            2'd0:    r[127:96] = w;
            2'd1:    r[95:64]  = w;
            2'd2:    r[63:32]  = w;
            default: r[31:0]   = w;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dcache_blk_master.sv
// Moves one 128-bit block between a register interface and the dcache word port.
// Optional start-time range rejection is enabled by defining DCBM_RANGE_CHK_EN.
module dcache_blk_master #(
    parameter int BLK_WORDS = 4,
    parameter int DEPTH     = 384
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         ld_start,
    input  logic         st_start,
    input  logic [31:0]  base_addr,
    input  logic [127:0] st_data,
    output logic [127:0] ld_data,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic         dc_re,
    output logic         dc_we,
    output logic [31:0]  dc_addr,
    output logic [31:0]  dc_wdata,
    input  logic [31:0]  dc_rdata
);
    import dcbm_pkg::*;

    localparam logic [1:0] LAST_BEAT = 2'(BLK_WORDS - 1);

    state_t       state_q, state_d;
    logic [1:0]   beat_q, beat_d;
    logic [31:0]  base_q, base_d;
    logic [127:0] st_data_q, st_data_d;
    logic [127:0] ld_data_q, ld_data_d;
    logic         done_q, done_d;
    logic         err_q, err_d;

    logic         start;
    logic         last_beat;
    logic         out_of_range;
    logic         reject;
    logic [32:0]  last_addr;

    assign start     = ld_start | st_start;
    assign last_beat = (beat_q == LAST_BEAT);

    // 33-bit sum so a wrap past 2^32 also lands above DEPTH.
    assign last_addr    = {1'b0, base_addr} + 33'(BLK_WORDS - 1);
    assign out_of_range = (last_addr >= 33'(DEPTH));

`ifdef DCBM_RANGE_CHK_EN
    assign reject = start & out_of_range;
`else
    logic range_unused;
    assign range_unused = out_of_range;
    assign reject       = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!reject) begin
                    if (ld_start)      state_d = LOAD;
                    else if (st_start) state_d = STORE;
                end
            end
            LOAD, STORE: begin
                if (last_beat) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        dc_re    = 1'b0;
        dc_we    = 1'b0;
        dc_addr  = '0;
        dc_wdata = '0;
        case (state_q)
            LOAD: begin
                dc_re   = 1'b1;
                dc_addr = base_q + 32'(beat_q);
            end
            STORE: begin
                dc_we    = 1'b1;
                dc_addr  = base_q + 32'(beat_q);
                dc_wdata = blk_word(st_data_q, beat_q);
            end
            default: ;
        endcase
    end

    always_comb begin
        beat_d    = beat_q;
        base_d    = base_q;
        st_data_d = st_data_q;
        ld_data_d = ld_data_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (reject) begin
                    done_d = 1'b1;
                    err_d  = 1'b1;
                end else if (start) begin
                    base_d = base_addr;
                    beat_d = '0;
                    // A simultaneous load wins, so the store block is not needed then.
                    if (!ld_start) st_data_d = st_data;
                end
            end
            LOAD: begin
                ld_data_d = blk_put(ld_data_q, beat_q, dc_rdata);
                beat_d    = beat_q + 2'd1;
                done_d    = last_beat;
            end
            STORE: begin
                beat_d = beat_q + 2'd1;
                done_d = last_beat;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            beat_q    <= '0;
            base_q    <= '0;
            st_data_q <= '0;
            ld_data_q <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            beat_q    <= beat_d;
            base_q    <= base_d;
            st_data_q <= st_data_d;
            ld_data_q <= ld_data_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign ld_data = ld_data_q;
    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign err     = err_q;

endmodule

// File: tb/tb_dcache_blk_master.sv
// Scoreboarded bench for dcache_blk_master with a behavioural dcache and reference model.
module tb_dcache_blk_master;
    localparam int DEPTH = 384;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         ld_start = 1'b0;
    logic         st_start = 1'b0;
    logic [31:0]  base_addr = '0;
    logic [127:0] st_data = '0;
    logic [127:0] ld_data;
    logic         busy, done, err, dc_re, dc_we;
    logic [31:0]  dc_addr, dc_wdata, dc_rdata;

    always #5 clk = ~clk;

    dcache_blk_master #(.BLK_WORDS(4), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .ld_start(ld_start), .st_start(st_start),
        .base_addr(base_addr), .st_data(st_data), .ld_data(ld_data), .busy(busy),
        .done(done), .err(err), .dc_re(dc_re), .dc_we(dc_we), .dc_addr(dc_addr),
        .dc_wdata(dc_wdata), .dc_rdata(dc_rdata)
    );

    // Behavioural dcache: combinational read, write at the edge, decodes addr[8:0].
    logic [31:0] mem [0:511];
    logic [31:0] init_val [0:511];
    logic        mem_init = 1'b0;
    assign dc_rdata = mem[dc_addr[8:0]];
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 512; i++) mem[i] <= init_val[i];
        end else if (dc_we) begin
            mem[dc_addr[8:0]] <= dc_wdata;
        end
    end

    int total = 0;
    int bad = 0;

    function automatic void chk(string nm, logic [127:0] act, logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endfunction

    typedef struct {bit is_load; bit err; logic [127:0] ld;} done_t;
    typedef struct {bit we; logic [31:0] addr; logic [31:0] wdata;} beat_t;
    done_t done_q[$];
    beat_t beat_q[$];

    logic [31:0]  ref_mem [0:511];
    logic [127:0] ref_ld = '0;

    beat_t mb;
    done_t md;
    always @(negedge clk) begin
        if (!reset) begin
            if (dc_re || dc_we) begin
                chk("strobe_excl", 128'(dc_re & dc_we), 128'(0));
                if (beat_q.size() == 0) begin
                    chk("unexpected_beat", 128'(dc_addr), 128'(32'hFFFF_FFFF));
                end else begin
                    mb = beat_q.pop_front();
                    chk("beat_we", 128'(dc_we), 128'(mb.we));
                    chk("beat_addr", 128'(dc_addr), 128'(mb.addr));
                    if (mb.we) chk("beat_wdata", 128'(dc_wdata), 128'(mb.wdata));
                end
            end else begin
                chk("idle_bus", {64'd0, dc_addr, dc_wdata}, 128'(0));
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    chk("unexpected_done", 128'(done), 128'(0));
                end else begin
                    md = done_q.pop_front();
                    chk("done_err", 128'(err), 128'(md.err));
                    chk("done_ld_data", ld_data, md.ld);
                    chk("done_busy", 128'(busy), 128'(0));
                end
            end
        end
    end

    // Reference model: what a transfer should do to the dcache and to ld_data.
    task automatic model(bit ld, bit st, logic [31:0] base, logic [127:0] data, output int lat);
        logic [31:0] a;
        logic [31:0] w [4];
        bit rej;
        rej = 1'b0;
`ifdef DCBM_RANGE_CHK_EN
        rej = (longint'(base) + 3 >= longint'(DEPTH));
`endif
        lat = 5;
        if (rej) begin
            lat = 1;
            done_q.push_back('{ld, 1'b1, ref_ld});
            return;
        end
        for (int k = 0; k < 4; k++) begin
            a = base + 32'(k);
            if (ld) begin
                w[k] = ref_mem[a[8:0]];
                beat_q.push_back('{1'b0, a, 32'd0});
            end else begin
                w[k] = data[127 - 32*k -: 32];
                ref_mem[a[8:0]] = w[k];
                beat_q.push_back('{1'b1, a, w[k]});
            end
        end
        if (ld) ref_ld = {w[0], w[1], w[2], w[3]};
        done_q.push_back('{ld, 1'b0, ref_ld});
    endtask

    // Called at a negedge; returns at the negedge of the done cycle.
    task automatic xfer(bit ld, bit st, logic [31:0] base, logic [127:0] data, bit poke);
        int lat;
        int n;
        ld_start = ld; st_start = st; base_addr = base; st_data = data;
        model(ld, st, base, data, lat);
        @(posedge clk);
        #1 ld_start = 1'b0; st_start = 1'b0;
        n = 0;
        while (1) begin
            @(negedge clk);
            n++;
            if (poke && n == 2) begin
                ld_start = 1'b1; st_start = 1'b1; base_addr = 32'd20; st_data = {4{32'hDEAD_BEEF}};
            end
            if (poke && n == 3) begin
                ld_start = 1'b0; st_start = 1'b0;
            end
            if (done || n >= 12) break;
        end
        chk("latency", 128'(n), 128'(lat));
    endtask

    logic [127:0] d2;
    logic [31:0]  rb;
    int           op;

    initial begin
        for (int i = 0; i < 512; i++) init_val[i] = $urandom;
        {init_val[0], init_val[1], init_val[2], init_val[3]} = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        {init_val[4], init_val[5], init_val[6], init_val[7]} = 128'h3243f6a8885a308d313198a2e0370734;
        for (int i = 0; i < 512; i++) ref_mem[i] = init_val[i];

        reset = 1'b1; mem_init = 1'b1;
        repeat (2) @(posedge clk);
        #1 mem_init = 1'b0;
        @(negedge clk);
        chk("rst_ld_data", ld_data, 128'(0));
        chk("rst_flags", {122'd0, busy, done, err, dc_re, dc_we, 1'b0}, 128'(0));
        chk("rst_bus", {64'd0, dc_addr, dc_wdata}, 128'(0));
        reset = 1'b0;
        @(negedge clk);

        xfer(1'b1, 1'b0, 32'd0, '0, 1'b0);
        chk("key_load", ld_data, 128'h2b7e151628aed2a6abf7158809cf4f3c);
        xfer(1'b1, 1'b0, 32'd4, '0, 1'b0);
        chk("pt_load", ld_data, 128'h3243f6a8885a308d313198a2e0370734);
        xfer(1'b0, 1'b1, 32'd8, 128'h3925841d02dc09fbdc118597196a0b32, 1'b0);
        chk("store_keeps_ld", ld_data, 128'h3243f6a8885a308d313198a2e0370734);
        xfer(1'b1, 1'b0, 32'd8, '0, 1'b0);
        chk("ct_readback", ld_data, 128'h3925841d02dc09fbdc118597196a0b32);

        // Both starts together, with ignored starts mid-transfer, then a start in the done cycle.
        xfer(1'b1, 1'b1, 32'd8, 128'h0123456789abcdef0011223344556677, 1'b1);
        xfer(1'b0, 1'b1, 32'd12, {$urandom, $urandom, $urandom, $urandom}, 1'b0);
        chk("mem8_intact", 128'(mem[8]), 128'(32'h3925841d));

        xfer(1'b1, 1'b0, 32'd382, '0, 1'b0);
`ifdef DCBM_RANGE_CHK_EN
        chk("reject_err", 128'(err), 128'(1));
`else
        chk("unchecked_err", 128'(err), 128'(0));
`endif

        // Reset after beat 1 of a store: words 8,9 land, 10,11 do not, no done.
        d2 = {$urandom, $urandom, $urandom, $urandom};
        st_start = 1'b1; base_addr = 32'd8; st_data = d2;
        beat_q.push_back('{1'b1, 32'd8, d2[127:96]});
        beat_q.push_back('{1'b1, 32'd9, d2[95:64]});
        ref_mem[8] = d2[127:96];
        ref_mem[9] = d2[95:64];
        @(posedge clk);
        #1 st_start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        ref_ld = '0;
        @(negedge clk);
        chk("abort_ld_data", ld_data, 128'(0));
        chk("abort_flags", {122'd0, busy, done, err, dc_re, dc_we, 1'b0}, 128'(0));
        chk("abort_bus", {64'd0, dc_addr, dc_wdata}, 128'(0));
        chk("abort_mem", {mem[8], mem[9], mem[10], mem[11]},
            {ref_mem[8], ref_mem[9], ref_mem[10], ref_mem[11]});
        chk("abort_mem10", 128'(mem[10]), 128'(32'hdc118597));
        chk("abort_beats", 128'(beat_q.size()), 128'(0));
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        for (int it = 0; it < 40; it++) begin
            op = $urandom_range(1, 3);
            case ($urandom_range(0, 3))
                0:       rb = 32'd378 + 32'($urandom_range(0, 8));
                1:       rb = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
                default: rb = 32'($urandom_range(0, 380));
            endcase
            xfer(op[0], op[1], rb, {$urandom, $urandom, $urandom, $urandom}, 1'b0);
        end

        repeat (3) @(negedge clk);
        chk("queues_drained", 128'(done_q.size() + beat_q.size()), 128'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
